// File: rtl/memory_pkg.sv
// Shared types for the burst master slice.
// State encoding and bus widths.
package memory_pkg;

  localparam int ADDR_W = 25;
  localparam int LEN_W  = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Next 32-bit word in 16-bit units, wrapping at 2^25.
  function automatic logic [ADDR_W-1:0] addr_step(
    input logic [ADDR_W-1:0] a
  );
    return a + ADDR_W'(2);
  endfunction

endpackage

// File: rtl/memory_burst_master_if.sv
// Bundle of command, stream and memory bus signals
// around memory_burst_master.
interface memory_burst_master_if;
  import memory_pkg::*;

  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] address;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              mem_request;
  logic              mem_write;
  logic              mem_busy;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;

  modport master (
    input  start, dir, address, length,
    input  wr_data, wr_valid, rd_ready,
    input  mem_busy, mem_ack, mem_data_in,
    output busy, done, wr_ready,
    output rd_data, rd_valid,
    output mem_request, mem_write,
    output mem_address, mem_data_out
  );

  modport slave (
    output start, dir, address, length,
    output wr_data, wr_valid, rd_ready,
    output mem_busy, mem_ack, mem_data_in,
    input  busy, done, wr_ready,
    input  rd_data, rd_valid,
    input  mem_request, mem_write,
    input  mem_address, mem_data_out
  );

endinterface

// File: rtl/memory_burst_fifo.sv
// Read-return buffer: synchronous FWFT FIFO
// with occupancy count.
module memory_burst_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  output logic [31:0]   o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, do_wr, do_rd;

  // Push at full is allowed only alongside a pop.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_rd    = i_pop && !empty;
    do_wr    = i_push && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  // Pointer and count registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates validity.
  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_valid = !empty;
  assign o_count = count_q;

endmodule

// File: rtl/memory_burst_master.sv
// Burst DMA master: streams words to or from a
// single-port memory controller.
module memory_burst_master
  import memory_pkg::*;
#(
  parameter int RD_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_dir,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_mem_request,
  output logic              o_mem_write,
  input  logic              i_mem_busy,
  input  logic              i_mem_ack,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data
);

  localparam int CW = $clog2(RD_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_issued_q, words_issued_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_flight;
  logic              done_q, done_d;
  logic              accept, rd_acc, ack_v, last;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = i_address[0];

  assign accept = o_mem_request && !i_mem_busy;
  assign rd_acc = accept && (state_q == READ);
  assign ack_v  = i_mem_ack &&
                  (state_q == READ || state_q == DRAIN);
  assign last   = (words_issued_q == len_q - LEN_W'(1));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_start && i_length != '0)
          state_d = i_dir ? WRITE : READ;
      end
      WRITE: if (accept && last) state_d = IDLE;
      READ:  if (accept && last) state_d = DRAIN;
      DRAIN: if (outstanding_d == '0) state_d = IDLE;
    endcase
  end

  // Bus outputs; reads throttle on buffer credit.
  always_comb begin
    o_mem_request = 1'b0;
    o_mem_write   = 1'b0;
    o_wr_ready    = 1'b0;
    in_flight     = {1'b0, outstanding_q} +
                    {1'b0, fifo_count};
    unique case (state_q)
      WRITE: begin
        o_mem_request = i_wr_valid;
        o_mem_write   = 1'b1;
        o_wr_ready    = i_wr_valid && !i_mem_busy;
      end
      READ: begin
        o_mem_request = (words_issued_q < len_q) &&
                        (in_flight < (CW+1)'(RD_DEPTH));
      end
      default: ;
    endcase
  end

  // Address, counters and completion pulse.
  always_comb begin
    addr_d         = addr_q;
    len_d          = len_q;
    words_issued_d = words_issued_q;
    done_d         = 1'b0;
    outstanding_d  = outstanding_q + CW'(rd_acc)
                     - CW'(ack_v);
    if (state_q == IDLE && i_start) begin
      addr_d         = {i_address[ADDR_W-1:1], 1'b0};
      len_d          = i_length;
      words_issued_d = '0;
      done_d         = (i_length == '0);
    end else if (accept) begin
      addr_d         = addr_step(addr_q);
      words_issued_d = words_issued_q + LEN_W'(1);
    end
    if (state_q == WRITE && accept && last)
      done_d = 1'b1;
    if (state_q == DRAIN && outstanding_d == '0)
      done_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q         <= '0;
      len_q          <= '0;
      words_issued_q <= '0;
      outstanding_q  <= '0;
      done_q         <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      len_q          <= len_d;
      words_issued_q <= words_issued_d;
      outstanding_q  <= outstanding_d;
      done_q         <= done_d;
    end
  end

  memory_burst_fifo #(
    .DEPTH (RD_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (ack_v),
    .i_data  (i_mem_data),
    .i_pop   (i_rd_ready),
    .o_data  (o_rd_data),
    .o_valid (o_rd_valid),
    .o_count (fifo_count)
  );

  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;
  assign o_mem_address = addr_q;
  assign o_mem_data    = i_wr_data;

endmodule

// File: tb/tb_memory_burst_master.sv
// Scoreboard bench for memory_burst_master with a
// behavioural memory controller and stream endpoints.
module tb_memory_burst_master;
  import memory_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic              w;
    logic [31:0]       d;
  } acc_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_burst_master_if bus();

  memory_burst_master #(.RD_DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (bus.start),
    .i_dir         (bus.dir),
    .i_address     (bus.address),
    .i_length      (bus.length),
    .o_busy        (bus.busy),
    .o_done        (bus.done),
    .i_wr_data     (bus.wr_data),
    .i_wr_valid    (bus.wr_valid),
    .o_wr_ready    (bus.wr_ready),
    .o_rd_data     (bus.rd_data),
    .o_rd_valid    (bus.rd_valid),
    .i_rd_ready    (bus.rd_ready),
    .o_mem_request (bus.mem_request),
    .o_mem_write   (bus.mem_write),
    .i_mem_busy    (bus.mem_busy),
    .i_mem_ack     (bus.mem_ack),
    .o_mem_address (bus.mem_address),
    .o_mem_data    (bus.mem_data_out),
    .i_mem_data    (bus.mem_data_in)
  );

  acc_t        exp_acc[$];
  logic [31:0] exp_rd[$];
  ack_t        pend[$];
  logic [31:0] wr_q[$];
  logic [31:0] mem [logic [ADDR_W-1:0]];

  int total = 0, bad = 0, cyc = 0;
  int done_cnt = 0, acc_cnt = 0, rd_acc_cnt = 0;
  int out_m = 0, cnt_m = 0;
  int busy_mode = 2;
  bit rd_low = 0, rd_rand = 0, wr_rand = 0, wr_taken = 0;
  bit stall_prev = 0;
  acc_t stall_acc;
  logic [ADDR_W-1:0] last_addr = '0;

  function automatic logic [31:0] peek(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {7'h55, a} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory controller: busy pattern and fixed-latency acks.
  always @(posedge clk) begin
    #1;
    case (busy_mode)
      0:       bus.mem_busy = ($urandom_range(0, 2) == 0);
      1:       bus.mem_busy = ~bus.mem_busy;
      default: bus.mem_busy = 1'b0;
    endcase
    bus.mem_ack     = 1'b0;
    bus.mem_data_in = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      bus.mem_ack     = 1'b1;
      bus.mem_data_in = pend[0].d;
      pend.delete(0);
    end
  end

  // Write source and read sink.
  always @(posedge clk) begin
    #1;
    if (wr_taken) begin
      wr_q.delete(0);
      wr_taken     = 0;
      bus.wr_valid = 1'b0;
    end
    if (!bus.wr_valid && wr_q.size() > 0) begin
      bus.wr_valid = wr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.wr_data  = wr_q[0];
    end
    bus.rd_ready = rd_low  ? 1'b0 :
                   rd_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: compare outputs, then apply this edge's events.
  always @(negedge clk) begin
    acc_t e;
    if (rst) begin
      exp_acc.delete();
      exp_rd.delete();
      pend.delete();
      wr_q.delete();
      bus.wr_valid = 1'b0;
      wr_taken     = 0;
      out_m        = 0;
      cnt_m        = 0;
      stall_prev   = 0;
    end else begin
      if (stall_prev) begin
        check("hold_req", 32'(bus.mem_request), 32'(1));
        check("hold_addr", 32'(bus.mem_address), 32'(stall_acc.a));
        check("hold_wr", 32'(bus.mem_write), 32'(stall_acc.w));
        if (stall_acc.w)
          check("hold_data", bus.mem_data_out, stall_acc.d);
      end
      check("rd_valid", 32'(bus.rd_valid), 32'(cnt_m > 0));
      if (!bus.busy)
        check("idle_req", 32'(bus.mem_request), 32'(0));
      if (bus.mem_request && !bus.mem_write)
        check("rd_credit", 32'(out_m + cnt_m < DEPTH), 32'(1));
      if (bus.mem_request && !bus.mem_busy) begin
        acc_cnt++;
        last_addr = bus.mem_address;
        if (exp_acc.size() == 0) begin
          fail_now("acc_extra");
        end else begin
          e = exp_acc.pop_front();
          check("acc_addr", 32'(bus.mem_address), 32'(e.a));
          check("acc_write", 32'(bus.mem_write), 32'(e.w));
          if (e.w) begin
            check("acc_data", bus.mem_data_out, e.d);
            check("wr_hs", 32'(bus.wr_valid && bus.wr_ready), 32'(1));
            mem[bus.mem_address] = bus.mem_data_out;
          end else begin
            pend.push_back('{cyc + LAT, peek(bus.mem_address)});
            out_m++;
            rd_acc_cnt++;
          end
        end
      end
      if (bus.mem_ack) begin
        out_m--;
        cnt_m++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        cnt_m--;
        if (exp_rd.size() == 0) fail_now("rd_extra");
        else check("rd_data", bus.rd_data, exp_rd.pop_front());
      end
      if (bus.wr_valid && bus.wr_ready) wr_taken = 1;
      if (bus.done) done_cnt++;
      stall_prev  = bus.mem_request && bus.mem_busy;
      stall_acc.a = bus.mem_address;
      stall_acc.w = bus.mem_write;
      stall_acc.d = bus.mem_data_out;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) fail_now("idle_timeout");
  endtask

  task automatic issue(input bit dir,
                       input logic [ADDR_W-1:0] addr,
                       input int len,
                       input bit seq,
                       input logic [31:0] dbase);
    logic [ADDR_W-1:0] a;
    acc_t e;
    a = {addr[ADDR_W-1:1], 1'b0};
    for (int k = 0; k < len; k++) begin
      e.a = a;
      e.w = dir;
      e.d = '0;
      if (dir) begin
        e.d = seq ? dbase + 32'(k) : $urandom;
        wr_q.push_back(e.d);
      end else begin
        exp_rd.push_back(peek(a));
      end
      exp_acc.push_back(e);
      a = a + ADDR_W'(2);
    end
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.dir     = dir;
    bus.address = addr;
    bus.length  = 16'(len);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) begin
      fail_now(name);
    end else begin
      check("busy_at_done", 32'(bus.busy), 32'(0));
      check("acc_left", 32'(exp_acc.size()), 32'(0));
      check("acks_left", 32'(out_m), 32'(0));
      @(negedge clk);
      #1;
      check("done_width", 32'(bus.done), 32'(0));
    end
    rd_low = 0;
    n = 0;
    while (exp_rd.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rd_left", 32'(exp_rd.size()), 32'(0));
  endtask

  initial begin
    int r0, a0, d0, n, len;
    bus.start    = 1'b0;
    bus.dir      = 1'b0;
    bus.address  = '0;
    bus.length   = '0;
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    bus.mem_busy = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_data_in = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_req", 32'(bus.mem_request), 32'(0));
    check("rst_wrrdy", 32'(bus.wr_ready), 32'(0));
    check("rst_rdval", 32'(bus.rd_valid), 32'(0));
    check("rst_addr", 32'(bus.mem_address), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write burst against a toggling busy.
    busy_mode = 1;
    wr_rand   = 0;
    issue(1'b1, 25'h0000100, 3, 1'b1, 32'hA0);
    wait_done("wr_done", 100);
    check("wr_last_addr", 32'(last_addr), 32'h104);

    // Read burst with the sink stalled.
    busy_mode = 2;
    rd_low    = 1;
    r0 = rd_acc_cnt;
    issue(1'b0, 25'h0000100, 8, 1'b0, '0);
    repeat (30) @(negedge clk);
    #1;
    check("rd_blocked_accepts", 32'(rd_acc_cnt - r0), 32'(4));
    check("rd_blocked_req", 32'(bus.mem_request), 32'(0));
    check("rd_blocked_valid", 32'(bus.rd_valid), 32'(1));
    rd_low = 0;
    wait_done("rd_done", 200);
    check("rd_total_accepts", 32'(rd_acc_cnt - r0), 32'(8));

    // Address wrap at the top of the space.
    issue(1'b0, 25'h1FFFFFC, 3, 1'b0, '0);
    wait_done("wrap_done", 100);
    check("wrap_last_addr", 32'(last_addr), 32'(0));

    // Zero length completes without touching memory.
    a0 = acc_cnt;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.dir    = 1'b0;
    bus.length = '0;
    @(negedge clk);
    check("zl_done_early", 32'(bus.done), 32'(0));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("zl_done", 32'(bus.done), 32'(1));
    check("zl_busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    check("zl_done_width", 32'(bus.done), 32'(0));
    check("zl_no_access", 32'(acc_cnt - a0), 32'(0));
    check("zl_done_count", 32'(done_cnt - d0), 32'(1));

    // Reset in the middle of a read.
    r0 = rd_acc_cnt;
    issue(1'b0, 25'h0000400, 5, 1'b0, '0);
    n = 0;
    while (rd_acc_cnt < r0 + 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rd_acc_cnt < r0 + 2) fail_now("rst_mid_wait");
    @(posedge clk);
    #1;
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_req", 32'(bus.mem_request), 32'(0));
    check("rst_mid_valid", 32'(bus.rd_valid), 32'(0));
    check("rst_mid_busy", 32'(bus.busy), 32'(0));
    check("rst_mid_addr", 32'(bus.mem_address), 32'(0));
    repeat (10) @(negedge clk);
    check("rst_mid_nodone", 32'(done_cnt - d0), 32'(0));
    issue(1'b0, 25'h0000800, 1, 1'b0, '0);
    wait_done("post_rst_done", 100);

    // Dense read traffic: acks, accepts and pops overlap.
    rd_rand = 1;
    issue(1'b0, 25'h0000100, 12, 1'b0, '0);
    wait_done("dense_done", 400);

    // Randomized mixed commands.
    wr_rand = 1;
    for (int i = 0; i < 16; i++) begin
      busy_mode = $urandom_range(0, 2);
      len = $urandom_range(0, 9);
      wait_idle();
      issue(($urandom_range(0, 1) == 1),
            ADDR_W'($urandom), len, 1'b0, '0);
      wait_done("rand_done", 500);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/memory_burst_master.md
MEMORY_BURST_MASTER -- requirements
Module: memory_burst_master

Interface
REQ-001 SHALL have the following parameter:
- RD_DEPTH, default 4, read-return buffer depth in words (power of 2, at least 2).

REQ-002 SHALL have the following ports, clock and reset first:
- i_clk, in, 1, clock.
- i_reset, in, 1, reset: synchronous, active-high.
- i_start, in, 1, command strobe; sampled only in IDLE.
- i_dir, in, 1, direction: 1 = write to memory, 0 = read from memory.
- i_address, in, 25, start address in 16-bit units; bit 0 ignored and forced to 0.
- i_length, in, 16, transfer length in 32-bit words.
- o_busy, out, 1, high whenever the state is not IDLE.
- o_done, out, 1, one-cycle pulse at command completion.
- i_wr_data, in, 32, write stream data.
- i_wr_valid, in, 1, write stream valid.
- o_wr_ready, out, 1, write stream ready.
- o_rd_data, out, 32, read stream data.
- o_rd_valid, out, 1, read stream valid.
- i_rd_ready, in, 1, read stream ready.
- o_mem_request, out, 1, memory controller request.
- o_mem_write, out, 1, memory controller write flag.
- i_mem_busy, in, 1, memory controller busy; may depend combinationally on o_mem_request.
- i_mem_ack, in, 1, read data valid pulse.
- o_mem_address, out, 25, memory controller address.
- o_mem_data, out, 32, memory controller write data.
- i_mem_data, in, 32, memory controller read data.

Function
REQ-003 SHALL treat a memory access as accepted in any cycle where o_mem_request is high and i_mem_busy is low.
REQ-004 SHALL implement states IDLE, WRITE, READ and DRAIN.
REQ-005 In IDLE with i_start high, SHALL latch the address, length and direction:
- i_length == 0: stay in IDLE and pulse o_done in the next cycle;
- otherwise: go to WRITE if i_dir is 1, else READ.
REQ-006 o_mem_request SHALL NOT assert earlier than the cycle after the i_start cycle.
REQ-007 In WRITE:
- o_mem_request = i_wr_valid;
- o_mem_write = 1;
- o_mem_data = i_wr_data, combinational;
- o_wr_ready = i_wr_valid && !i_mem_busy, so a stream handshake occurs exactly on acceptance.
REQ-008 When the last write is accepted, SHALL go to IDLE and pulse o_done in the next cycle.
REQ-009 In READ:
- o_mem_write = 0;
- o_mem_request = (words_issued < length) && (outstanding + fifo_count < RD_DEPTH);
- o_wr_ready = 0.
REQ-010 After the last read is accepted, SHALL go to DRAIN.
REQ-011 In DRAIN, SHALL go to IDLE once outstanding == 0 and the ack of that cycle is processed; o_done SHALL pulse in the next cycle, independent of read-buffer emptiness.
REQ-012 Each accepted access SHALL advance o_mem_address by 2, wrapping modulo 2^25 (0x1FFFFFE -> 0x0000000).
REQ-013 The outstanding counter SHALL:
- +1 on an accepted read;
- -1 on i_mem_ack;
- remain unchanged when both occur in the same cycle.
REQ-014 Each i_mem_ack SHALL push i_mem_data into the RD_DEPTH read buffer; by REQ-009 the buffer can never overflow.
REQ-015 o_rd_valid SHALL equal buffer not empty; a pop SHALL occur on o_rd_valid && i_rd_ready; a simultaneous push and pop at full or empty SHALL be lossless.
REQ-016 i_start SHALL be ignored while o_busy is high.
REQ-017 o_mem_request SHALL stay high until accepted, with address, write flag and data stable.
REQ-018 i_mem_ack outside READ/DRAIN SHALL be ignored, with no push.

Reset
REQ-019 On i_reset, the block SHALL:
- go to IDLE;
- clear counters and flush the read buffer;
- drive o_busy, o_done, o_mem_request, o_wr_ready and o_rd_valid to 0;
- drive o_mem_address to 0.
REQ-020 Reset mid-transfer SHALL abort without an o_done pulse; o_mem_request SHALL be low in the cycle after reset is sampled.

Structure
REQ-021 SHALL place the state encoding in shared package memory_pkg: IDLE=0, WRITE=1, READ=2, DRAIN=3, 2 bits.
REQ-022 The read buffer SHALL be sub-module memory_burst_fifo: synchronous, first-word-fall-through, RD_DEPTH x 32, with count output.
REQ-023 Counters SHALL be sized as follows: words_issued 16 bits; outstanding and fifo_count log2(RD_DEPTH)+1 bits.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Write burst: i_address=0x0000100, i_length=3, wr stream 0xA0,0xA1,0xA2 with i_mem_busy toggling every cycle -> three accepts at addresses 0x100, 0x102, 0x104 with matching data, then o_done pulse, o_busy low.
- Read burst: i_length=8, controller acks 3 cycles after each accept, i_rd_ready held low -> at most 4 requests accepted; request deasserts while outstanding+count=4; raising i_rd_ready resumes; 8 words delivered in order; o_done pulse after the 8th ack.
- Wrap: i_address=0x1FFFFFC, i_length=3 read -> addresses 0x1FFFFFC, 0x1FFFFFE, 0x0000000.
- Zero length: i_length=0 -> no o_mem_request, o_done pulse 1 cycle after i_start.
- Reset mid-operation: i_reset asserted after the 2nd of 5 read accepts -> o_mem_request low next cycle, o_rd_valid 0, no o_done; a new i_length=1 read completes normally.
- Concurrency: ack, accept, and pop in the same cycle with buffer full -> no data lost, counters consistent, checked against a scoreboard.
